cr16_datapath_sequencer: RTL and testbench
==========================================

# cr16_datapath_sequencer

Programmable controller that drives the CR16 register-file/ALU datapath from a small loadable program memory, replacing hard-wired per-state test sequences. On a start pulse it fetches 32-bit micro-instructions from address 0 and issues one datapath operation (opcode, read-port selects, one-hot write enable, immediate) per instruction. It stops on a HALT word or after the last address. It sits between the board-level test harness (program load and start) and the datapath control inputs.

## Interface
- DEPTH, 16, program words; power of two, 2..256; ADDR_W = $clog2(DEPTH)
- I_CLK  in  1  system clock, rising edge
- I_RESET  in  1  asynchronous, active-high reset
- I_ENABLE  in  1  run enable; low freezes the sequencer
- I_START  in  1  start pulse, sampled in IDLE only
- I_PROG_WE  in  1  program-memory write strobe
- I_PROG_ADDR  in  ADDR_W  program write address
- I_PROG_DATA  in  32  instruction word: [31:28] opcode, [27:24] dst, [23:20] srcA, [19:16] srcB, [15:0] imm
- O_OPCODE  out  4  ALU opcode
- O_READ_PORT_A_SEL  out  4  binary read select A
- O_READ_PORT_B_SEL  out  4  binary read select B
- O_REG_ENABLE  out  16  one-hot register write enable
- O_PRELOAD_IMM  out  16  immediate operand
- O_BUSY  out  1  high outside IDLE
- O_DONE  out  1  one-cycle completion pulse
- O_PC  out  ADDR_W  current program address

## Operation
- States are IDLE, FETCH, EXEC and DONE. When CR16_SEQ_STEP_EN is defined, a fifth state, WAIT_STEP, is added.
- IDLE: when I_START=1 and I_ENABLE=1, clear PC to 0 and go to FETCH.
- FETCH: perform a synchronous read of mem[PC] into the instruction register IR, then go to EXEC.
- EXEC: drive the outputs from IR, then:
  - if IR.opcode = HALT_OP (4'hF), suppress the write and go to DONE;
  - else if PC = DEPTH-1, go to DONE;
  - else PC <= PC+1 and go to FETCH.
- DONE: O_DONE=1 for this cycle only, then go to IDLE.
- Output decode in EXEC:
  - O_REG_ENABLE = 16'h1 << IR.dst.
  - The other outputs come straight from the IR fields.
  - Outside EXEC, and for HALT, all datapath outputs are 0.
- I_ENABLE=0 in any non-IDLE state:
  - state, PC and IR hold;
  - O_REG_ENABLE is forced to 0; the other outputs keep their decode;
  - the sequence resumes in the same state on the next enabled cycle.
- I_START while busy is ignored.
- I_PROG_WE:
  - accepted only in IDLE, including the cycle that samples I_START; a FETCH in the next cycle sees the new word;
  - ignored while busy; no error flag.
- Program memory is not cleared by reset.
- Reset, asynchronous and at any time including mid-program:
  - state goes to IDLE, PC=0, IR=0;
  - every output is 0 (O_BUSY=0, O_DONE=0, O_REG_ENABLE=0).

## Timing
- All outputs are registered or decoded from registered state; no I_* input reaches an output combinationally, except I_ENABLE gating O_REG_ENABLE.
- I_START sampled at edge t gives FETCH in cycle t+1 and the first EXEC (write enable) in cycle t+2.
- Each instruction costs 2 cycles (FETCH + EXEC).
- A program of N non-HALT instructions ending in HALT gives O_DONE in cycle t+2(N+1)+1 and O_BUSY falling one cycle after that.
- The datapath captures the write on the rising edge that ends EXEC.

## Configuration
- Macro: CR16_SEQ_STEP_EN.
- Defined:
  - adds input ports I_STEP_MODE (1 bit) and I_STEP (1 bit);
  - when I_STEP_MODE=1, IDLE-start and every non-final EXEC go to WAIT_STEP instead of FETCH;
  - WAIT_STEP goes to FETCH when I_STEP=1 and I_ENABLE=1.
- I_STEP_MODE=0 behaves exactly like the undefined build.
- Undefined: no extra ports and no WAIT_STEP; the sequencer free-runs.

## Structure
- Package cr16_seq_pkg holds:
  - the state enum;
  - HALT_OP;
  - instruction field bit-position constants;
  - the instruction-word struct/typedef.
- Sub-module cr16_seq_prog_mem: DEPTH×32 single-port RAM with synchronous read and write and read-enable; no reset of contents.

## Test plan
- Fibonacci:
  - program: r0=imm 1, r1=imm 1, then r2=r0+r1 … r7=r5+r6, then HALT at address 8;
  - required: O_REG_ENABLE sequence 0001, 0002, 0004 … 0080, each in an EXEC cycle;
  - O_DONE 19 cycles after start; the register file holds 1 1 2 3 5 8 13 21.
- HALT at address 0 -> no write enable ever asserted; O_DONE 3 cycles after start.
- Full memory (DEPTH=16), no HALT -> 16 write pulses; O_PC reaches 15; O_DONE after 33 cycles.
- I_ENABLE low for 5 cycles during EXEC of instruction 3 -> O_REG_ENABLE=0 while low; the write occurs on resume; final result identical; completion delayed by 5 cycles.
- Reset mid-run, then restart:
  - I_RESET asserted mid-EXEC -> all outputs 0 immediately (before the next edge);
  - a restart reruns from address 0 with the program intact.
- Start/write while busy, plus step mode:
  - I_START and I_PROG_WE pulsed while busy -> ignored; memory unchanged;
  - with CR16_SEQ_STEP_EN defined and I_STEP_MODE=1 -> exactly one instruction executes per I_STEP pulse.

Source files
------------

// File: rtl/cr16_seq_pkg.sv
// Shared types and constants for the CR16 datapath sequencer.
// CR16_SEQ_STEP_EN adds the WAIT_STEP state used by single-step mode.
package cr16_seq_pkg;

   localparam logic [3:0] HALT_OP = 4'hF;

   localparam int OPC_LSB  = 28;
   localparam int DST_LSB  = 24;
   localparam int SRCA_LSB = 20;
   localparam int SRCB_LSB = 16;
   localparam int IMM_LSB  = 0;
   localparam int FIELD_W  = 4;
   localparam int IMM_W    = 16;

   typedef struct packed {
      logic [3:0]  opcode;
      logic [3:0]  dst;
      logic [3:0]  src_a;
      logic [3:0]  src_b;
      logic [15:0] imm;
   } instr_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_DONE  = 3'd3
`ifdef CR16_SEQ_STEP_EN
      , ST_WAIT_STEP = 3'd4
`endif
   } state_t;

   function automatic instr_t to_instr(input logic [31:0] w);
      instr_t r;
      r.opcode = w[OPC_LSB  +: FIELD_W];
      r.dst    = w[DST_LSB  +: FIELD_W];
      r.src_a  = w[SRCA_LSB +: FIELD_W];
      r.src_b  = w[SRCB_LSB +: FIELD_W];
      r.imm    = w[IMM_LSB  +: IMM_W];
      return r;
   endfunction

endpackage

// File: rtl/cr16_seq_prog_mem.sv
// Single-port DEPTHx32 program RAM, synchronous write and enabled synchronous read.
// Contents are never reset; only the read register (the instruction register) is.
module cr16_seq_prog_mem #(
   parameter int DEPTH = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/cr16_datapath_sequencer.sv
// Micro-programmed controller issuing one CR16 datapath operation per loaded instruction.
// Optional single-step mode is compiled in with CR16_SEQ_STEP_EN.
import cr16_seq_pkg::*;

module cr16_datapath_sequencer #(
   parameter int DEPTH = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              I_CLK,
   input  logic              I_RESET,
   input  logic              I_ENABLE,
   input  logic              I_START,
`ifdef CR16_SEQ_STEP_EN
   input  logic              I_STEP_MODE,
   input  logic              I_STEP,
`endif
   input  logic              I_PROG_WE,
   input  logic [ADDR_W-1:0] I_PROG_ADDR,
   input  logic [31:0]       I_PROG_DATA,
   output logic [3:0]        O_OPCODE,
   output logic [3:0]        O_READ_PORT_A_SEL,
   output logic [3:0]        O_READ_PORT_B_SEL,
   output logic [15:0]       O_REG_ENABLE,
   output logic [15:0]       O_PRELOAD_IMM,
   output logic              O_BUSY,
   output logic              O_DONE,
   output logic [ADDR_W-1:0] O_PC
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state, state_next, fetch_state;
   logic [ADDR_W-1:0] pc, pc_next;
   logic [31:0]       ir_word;
   instr_t            ir;
   logic              mem_we, mem_re;
   logic [ADDR_W-1:0] mem_addr;

   // The port is shared: IDLE owns it for program loads, FETCH for reads.
   assign mem_we   = I_PROG_WE && (state == ST_IDLE);
   assign mem_re   = I_ENABLE && (state == ST_FETCH);
   assign mem_addr = (state == ST_IDLE) ? I_PROG_ADDR : pc;
   assign ir       = to_instr(ir_word);

   cr16_seq_prog_mem #(.DEPTH(DEPTH)) u_prog_mem (
      .clk   (I_CLK),
      .rst   (I_RESET),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (I_PROG_DATA),
      .rdata (ir_word)
   );

`ifdef CR16_SEQ_STEP_EN
   assign fetch_state = I_STEP_MODE ? ST_WAIT_STEP : ST_FETCH;
`else
   assign fetch_state = ST_FETCH;
`endif

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         state <= ST_IDLE;
         pc    <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      if (I_ENABLE) begin
         case (state)
            ST_IDLE: begin
               if (I_START) begin
                  pc_next    = '0;
                  state_next = fetch_state;
               end
            end
            ST_FETCH: state_next = ST_EXEC;
            ST_EXEC: begin
               if (ir.opcode == HALT_OP || pc == LAST_ADDR) begin
                  state_next = ST_DONE;
               end else begin
                  pc_next    = pc + 1'b1;
                  state_next = fetch_state;
               end
            end
            ST_DONE: state_next = ST_IDLE;
`ifdef CR16_SEQ_STEP_EN
            ST_WAIT_STEP: begin
               if (I_STEP) state_next = ST_FETCH;
            end
`endif
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Disabling only blocks the write; the rest of the decode stays visible.
   always_comb begin
      O_OPCODE          = '0;
      O_READ_PORT_A_SEL = '0;
      O_READ_PORT_B_SEL = '0;
      O_REG_ENABLE      = '0;
      O_PRELOAD_IMM     = '0;
      if (state == ST_EXEC && ir.opcode != HALT_OP) begin
         O_OPCODE          = ir.opcode;
         O_READ_PORT_A_SEL = ir.src_a;
         O_READ_PORT_B_SEL = ir.src_b;
         O_PRELOAD_IMM     = ir.imm;
         O_REG_ENABLE      = I_ENABLE ? (16'h1 << ir.dst) : 16'h0;
      end
      O_BUSY = (state != ST_IDLE);
      O_DONE = (state == ST_DONE);
      O_PC   = pc;
   end

endmodule

// File: tb/tb_cr16_datapath_sequencer.sv
// Directed bench for cr16_datapath_sequencer with a small register-file/ALU model.
// Step-mode scenario is included when CR16_SEQ_STEP_EN is defined.
`timescale 1ns/1ps
module tb_cr16_datapath_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        start = 1'b0;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = '0;
   logic [31:0] prog_data = '0;
`ifdef CR16_SEQ_STEP_EN
   logic        step_mode = 1'b0;
   logic        step = 1'b0;
`endif
   logic [3:0]  opcode, sel_a, sel_b, pc;
   logic [15:0] reg_en, imm;
   logic        busy, done;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   cr16_datapath_sequencer #(.DEPTH(16)) dut (
      .I_CLK             (clk),
      .I_RESET           (rst),
      .I_ENABLE          (en),
      .I_START           (start),
`ifdef CR16_SEQ_STEP_EN
      .I_STEP_MODE       (step_mode),
      .I_STEP            (step),
`endif
      .I_PROG_WE         (prog_we),
      .I_PROG_ADDR       (prog_addr),
      .I_PROG_DATA       (prog_data),
      .O_OPCODE          (opcode),
      .O_READ_PORT_A_SEL (sel_a),
      .O_READ_PORT_B_SEL (sel_b),
      .O_REG_ENABLE      (reg_en),
      .O_PRELOAD_IMM     (imm),
      .O_BUSY            (busy),
      .O_DONE            (done),
      .O_PC              (pc)
   );

   // Datapath model: opcode 0 loads the immediate, opcode 1 adds A+B.
   logic [15:0] rf [16];
   logic [15:0] wlog [$];
   logic        clr_model = 1'b0;

   always @(negedge clk) begin
      if (clr_model) begin
         for (int i = 0; i < 16; i++) rf[i] <= '0;
         wlog.delete();
      end else if (reg_en != 16'h0) begin
         for (int i = 0; i < 16; i++) begin
            if (reg_en[i]) begin
               case (opcode)
                  4'h0:    rf[i] <= imm;
                  4'h1:    rf[i] <= rf[sel_a] + rf[sel_b];
                  default: rf[i] <= 16'hDEAD;
               endcase
            end
         end
         wlog.push_back(reg_en);
      end
   end

   int          r_done, r_maxpc;
   logic        r_busy_after;
   logic [15:0] r_stall_we;
   logic [3:0]  r_stall_opc;
   logic [3:0]  x_opc, x_pc;
   logic [15:0] x_en, x_imm;
   int          fib_exp [8] = '{1, 1, 2, 3, 5, 8, 13, 21};

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] b,
                                      input logic [15:0] v);
      return {op, d, a, b, v};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_model();
      clr_model = 1'b1;
      @(negedge clk);
      #1;
      clr_model = 1'b0;
   endtask

   task automatic load_word(input logic [3:0] a, input logic [31:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic load_fib();
      load_word(4'd0, mk(4'h0, 4'd0, 4'd0, 4'd0, 16'd1));
      load_word(4'd1, mk(4'h0, 4'd1, 4'd0, 4'd0, 16'd1));
      for (int k = 2; k < 8; k++)
         load_word(4'(k), mk(4'h1, 4'(k), 4'(k - 2), 4'(k - 1), 16'd0));
      load_word(4'd8, 32'hF000_0000);
   endtask

   // Starts the loaded program; n counts edges from the one that samples I_START.
   task automatic run_prog(input int stall_n, input int stall_len, input int poke_n);
      r_done = -1; r_maxpc = 0; r_busy_after = 1'b1;
      r_stall_we = '0; r_stall_opc = '0;
      start = 1'b1; en = 1'b1;
      for (int n = 1; n <= 150; n++) begin
         tick();
         if (n == 1) start = 1'b0;
         if (n == 2) begin x_opc = opcode; x_en = reg_en; x_imm = imm; x_pc = pc; end
         if (int'(pc) > r_maxpc) r_maxpc = int'(pc);
         if (r_done >= 0) begin
            r_busy_after = busy;
            break;
         end
         if (done) r_done = n;
         if (stall_len > 0 && n == stall_n) en = 1'b0;
         if (stall_len > 0 && n == stall_n + stall_len) en = 1'b1;
         if (n == poke_n) begin
            start = 1'b1; prog_we = 1'b1; prog_addr = 4'd2; prog_data = 32'hF000_0000;
         end
         if (poke_n > 0 && n == poke_n + 1) begin start = 1'b0; prog_we = 1'b0; end
         #1;
         if (!en) begin r_stall_we |= reg_en; r_stall_opc = opcode; end
      end
      start = 1'b0; prog_we = 1'b0; en = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (reg_en !== 16'h0) begin bad++; $display("FAIL reset_regen got=%h want=0000", reg_en); end
      total++; if (pc !== 4'h0)     begin bad++; $display("FAIL reset_pc got=%0d want=0", pc); end
      total++; if (opcode !== 4'h0) begin bad++; $display("FAIL reset_opcode got=%h want=0", opcode); end
      tick(); rst = 1'b0; en = 1'b1;
      tick(); tick();
      total++; if (busy !== 1'b0)   begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
      $display("reset: busy=%b done=%b pc=%0d", busy, done, pc);
   endtask

   task automatic test_fibonacci();
      load_fib();
      reset_model();
      run_prog(0, 0, 0);
      $display("fibonacci: done_n=%0d writes=%0d r7=%0d", r_done, wlog.size(), rf[7]);
      total++; if (r_done !== 19) begin bad++; $display("FAIL fib_done_cycle got=%0d want=19", r_done); end
      total++; if (r_busy_after !== 1'b0) begin bad++; $display("FAIL fib_busy_after got=%b want=0", r_busy_after); end
      total++; if (r_maxpc !== 8) begin bad++; $display("FAIL fib_max_pc got=%0d want=8", r_maxpc); end
      total++; if (x_opc !== 4'h0 || x_en !== 16'h0001 || x_imm !== 16'd1 || x_pc !== 4'd0) begin
         bad++; $display("FAIL fib_first_exec got op=%h en=%h imm=%h pc=%0d want op=0 en=0001 imm=0001 pc=0",
                         x_opc, x_en, x_imm, x_pc);
      end
      total++; if (wlog.size() !== 8) begin bad++; $display("FAIL fib_write_count got=%0d want=8", wlog.size()); end
      for (int i = 0; i < 8 && i < wlog.size(); i++) begin
         total++;
         if (wlog[i] !== (16'h1 << i)) begin
            bad++; $display("FAIL fib_regen_%0d got=%h want=%h", i, wlog[i], 16'h1 << i);
         end
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (rf[i] !== 16'(fib_exp[i])) begin
            bad++; $display("FAIL fib_rf_%0d got=%0d want=%0d", i, rf[i], fib_exp[i]);
         end
      end
   endtask

   task automatic test_halt_first();
      load_word(4'd0, 32'hF300_0007);
      reset_model();
      run_prog(0, 0, 0);
      $display("halt_first: done_n=%0d writes=%0d", r_done, wlog.size());
      total++; if (r_done !== 3) begin bad++; $display("FAIL halt0_done_cycle got=%0d want=3", r_done); end
      total++; if (wlog.size() !== 0) begin bad++; $display("FAIL halt0_writes got=%0d want=0", wlog.size()); end
      total++; if (r_busy_after !== 1'b0) begin bad++; $display("FAIL halt0_busy_after got=%b want=0", r_busy_after); end
   endtask

   task automatic test_full_memory();
      for (int k = 0; k < 16; k++) load_word(4'(k), mk(4'h0, 4'(k), 4'd0, 4'd0, 16'(100 + k)));
      reset_model();
      run_prog(0, 0, 0);
      $display("full_memory: done_n=%0d writes=%0d max_pc=%0d", r_done, wlog.size(), r_maxpc);
      total++; if (r_done !== 33) begin bad++; $display("FAIL full_done_cycle got=%0d want=33", r_done); end
      total++; if (wlog.size() !== 16) begin bad++; $display("FAIL full_writes got=%0d want=16", wlog.size()); end
      total++; if (r_maxpc !== 15) begin bad++; $display("FAIL full_max_pc got=%0d want=15", r_maxpc); end
      total++; if (rf[15] !== 16'd115 || rf[0] !== 16'd100) begin
         bad++; $display("FAIL full_rf got r0=%0d r15=%0d want r0=100 r15=115", rf[0], rf[15]);
      end
   endtask

   task automatic test_enable_stall();
      load_fib();
      reset_model();
      run_prog(8, 5, 0);
      $display("enable_stall: done_n=%0d stall_we=%h stall_op=%h r7=%0d", r_done, r_stall_we, r_stall_opc, rf[7]);
      total++; if (r_done !== 24) begin bad++; $display("FAIL stall_done_cycle got=%0d want=24", r_done); end
      total++; if (r_stall_we !== 16'h0) begin bad++; $display("FAIL stall_regen got=%h want=0000", r_stall_we); end
      total++; if (r_stall_opc !== 4'h1) begin bad++; $display("FAIL stall_opcode got=%h want=1", r_stall_opc); end
      total++; if (wlog.size() !== 8 || rf[7] !== 16'd21 || rf[3] !== 16'd3) begin
         bad++; $display("FAIL stall_result got writes=%0d r3=%0d r7=%0d want 8 3 21", wlog.size(), rf[3], rf[7]);
      end
   endtask

   task automatic test_reset_mid_run();
      reset_model();
      start = 1'b1; en = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         tick();
         start = 1'b0;
      end
      total++; if (reg_en !== 16'h0004) begin bad++; $display("FAIL midrst_pre_regen got=%h want=0004", reg_en); end
      #1 rst = 1'b1;
      #1;
      $display("reset_mid_run: busy=%b regen=%h op=%h pc=%0d", busy, reg_en, opcode, pc);
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_status got busy=%b done=%b want 0 0", busy, done); end
      total++; if (reg_en !== 16'h0 || opcode !== 4'h0 || sel_a !== 4'h0 || sel_b !== 4'h0 || imm !== 16'h0) begin
         bad++; $display("FAIL midrst_datapath got en=%h op=%h a=%h b=%h imm=%h want all 0", reg_en, opcode, sel_a, sel_b, imm);
      end
      total++; if (pc !== 4'h0) begin bad++; $display("FAIL midrst_pc got=%0d want=0", pc); end
      tick(); tick();
      rst = 1'b0;
      reset_model();
      run_prog(0, 0, 0);
      $display("restart: done_n=%0d r7=%0d", r_done, rf[7]);
      total++; if (r_done !== 19) begin bad++; $display("FAIL restart_done_cycle got=%0d want=19", r_done); end
      total++; if (rf[7] !== 16'd21 || rf[6] !== 16'd13) begin
         bad++; $display("FAIL restart_rf got r6=%0d r7=%0d want 13 21", rf[6], rf[7]);
      end
   endtask

   task automatic test_busy_ignore();
      reset_model();
      run_prog(0, 0, 4);
      $display("busy_ignore: done_n=%0d r7=%0d", r_done, rf[7]);
      total++; if (r_done !== 19) begin bad++; $display("FAIL busy_done_cycle got=%0d want=19", r_done); end
      total++; if (rf[7] !== 16'd21) begin bad++; $display("FAIL busy_rf7 got=%0d want=21", rf[7]); end
      reset_model();
      run_prog(0, 0, 0);
      $display("busy_ignore_rerun: done_n=%0d writes=%0d", r_done, wlog.size());
      total++; if (r_done !== 19) begin bad++; $display("FAIL busy_mem_intact got=%0d want=19", r_done); end
      total++; if (wlog.size() !== 8) begin bad++; $display("FAIL busy_rerun_writes got=%0d want=8", wlog.size()); end
   endtask

`ifdef CR16_SEQ_STEP_EN
   task automatic test_step_mode();
      reset_model();
      step_mode = 1'b1; en = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         tick(); tick(); tick();
         total++;
         if (wlog.size() !== k || busy !== 1'b1) begin
            bad++; $display("FAIL step_hold_%0d got writes=%0d busy=%b want %0d 1", k, wlog.size(), busy, k);
         end
         step = 1'b1;
         tick();
         step = 1'b0;
         tick(); tick();
         $display("step %0d: writes=%0d done=%b", k, wlog.size(), done);
         total++;
         if (k < 8 && wlog.size() !== k + 1) begin
            bad++; $display("FAIL step_write_%0d got=%0d want=%0d", k, wlog.size(), k + 1);
         end else if (k == 8 && (done !== 1'b1 || wlog.size() !== 8)) begin
            bad++; $display("FAIL step_final got done=%b writes=%0d want 1 8", done, wlog.size());
         end
      end
      tick();
      step_mode = 1'b0;
      total++; if (rf[7] !== 16'd21) begin bad++; $display("FAIL step_rf7 got=%0d want=21", rf[7]); end
   endtask
`endif

   initial begin
      test_reset();
      test_fibonacci();
      test_halt_first();
      test_full_memory();
      test_enable_stall();
      test_reset_mid_run();
      test_busy_ignore();
`ifdef CR16_SEQ_STEP_EN
      test_step_mode();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
